// File: rtl/axi_rd_join_arbiter.sv
// Two-requester AXI read join: round-robin AR arbitration with the winner index prepended to the ID,
// R beats steered back by that ID MSB, and per-requester outstanding-burst throttling.
module axi_rd_join_arbiter #(
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int MaxTxns   = 8,
    localparam int CntW     = $clog2(MaxTxns + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0][IdWidth-1:0]         in_ar_id_i,
    input  logic [1:0][AddrWidth-1:0]       in_ar_addr_i,
    input  logic [1:0][7:0]                 in_ar_len_i,
    input  logic [1:0]                      in_ar_valid_i,
    output logic [1:0]                      in_ar_ready_o,
    output logic [IdWidth-1:0]              in_r_id_o,
    output logic [DataWidth-1:0]            in_r_data_o,
    output logic [1:0]                      in_r_resp_o,
    output logic                            in_r_last_o,
    output logic [1:0]                      in_r_valid_o,
    input  logic [1:0]                      in_r_ready_i,
    output logic [IdWidth:0]                out_ar_id_o,
    output logic [AddrWidth-1:0]            out_ar_addr_o,
    output logic [7:0]                      out_ar_len_o,
    output logic                            out_ar_valid_o,
    input  logic                            out_ar_ready_i,
    input  logic [IdWidth:0]                out_r_id_i,
    input  logic [DataWidth-1:0]            out_r_data_i,
    input  logic [1:0]                      out_r_resp_i,
    input  logic                            out_r_last_i,
    input  logic                            out_r_valid_i,
    output logic                            out_r_ready_o,
    output logic                            dbg_state_o,
    output logic                            dbg_rr_ptr_o,
    output logic [1:0][CntW-1:0]            dbg_cnt_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid is never withdrawn by this block once a request is locked.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    state_e               state_q;
    logic                 grant_q;
    logic                 rr_ptr_q;
    logic [1:0][CntW-1:0] cnt_q;
    logic [1:0][CntW-1:0] cnt_d;

    logic [1:0] eligible;
    logic       grant_idle;
    logic       grant;
    logic       ar_hs;
    logic       r_sel;
    logic       r_hs;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            eligible[i] = in_ar_valid_i[i] && (cnt_q[i] < MaxCnt);
        end
        grant_idle = eligible[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        grant      = (state_q == ST_LOCK) ? grant_q : grant_idle;
    end

    assign out_ar_valid_o = !rst_i && ((state_q == ST_LOCK) || (|eligible));
    assign ar_hs          = out_ar_valid_o && out_ar_ready_i;
    assign out_ar_id_o    = {grant, in_ar_id_i[grant]};
    assign out_ar_addr_o  = in_ar_addr_i[grant];
    assign out_ar_len_o   = in_ar_len_i[grant];

    always_comb begin
        in_ar_ready_o        = 2'b00;
        in_ar_ready_o[grant] = ar_hs;
    end

    // R steering: the extra ID MSB selects the requester and is stripped on return.
    assign r_sel         = out_r_id_i[IdWidth];
    assign in_r_id_o     = out_r_id_i[IdWidth-1:0];
    assign in_r_data_o   = out_r_data_i;
    assign in_r_resp_o   = out_r_resp_i;
    assign in_r_last_o   = out_r_last_i;
    assign out_r_ready_o = !rst_i && in_r_ready_i[r_sel];
    assign r_hs          = out_r_valid_i && out_r_ready_o;

    always_comb begin
        in_r_valid_o        = 2'b00;
        in_r_valid_o[r_sel] = out_r_valid_i && !rst_i;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic inc;
            logic dec;
            inc      = ar_hs && (grant == 1'(i));
            dec      = r_hs && out_r_last_i && (r_sel == 1'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (ar_hs) begin
                rr_ptr_q <= ~grant;
            end
            case (state_q)
                ST_IDLE: begin
                    if ((|eligible) && !out_ar_ready_i) begin
                        state_q <= ST_LOCK;
                        grant_q <= grant_idle;
                    end
                end
                ST_LOCK: begin
                    if (out_ar_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A beat for a requester with nothing outstanding means the downstream misbehaved.
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_hs) begin
            assert (cnt_q[r_sel] != '0)
            else $error("R beat returned to requester with no outstanding burst");
        end
    end

    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;
    assign dbg_cnt_o    = cnt_q;

endmodule

// File: tb/tb_axi_rd_join_arbiter.sv
// Scenario bench for axi_rd_join_arbiter with MaxTxns=2; AR and R traffic checked against expected queues.
module tb_axi_rd_join_arbiter;
  localparam int IW  = 4;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int MT  = 2;
  localparam int CW  = 2;
  localparam int ARW = IW + 1 + AW + 8;
  localparam int RW  = 2 + IW + DW + 2 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][IW-1:0] in_ar_id;
  logic [1:0][AW-1:0] in_ar_addr;
  logic [1:0][7:0]    in_ar_len;
  logic [1:0]         in_ar_valid;
  logic [1:0]         in_ar_ready;
  logic [IW-1:0]      in_r_id;
  logic [DW-1:0]      in_r_data;
  logic [1:0]         in_r_resp;
  logic               in_r_last;
  logic [1:0]         in_r_valid;
  logic [1:0]         in_r_ready;
  logic [IW:0]        out_ar_id;
  logic [AW-1:0]      out_ar_addr;
  logic [7:0]         out_ar_len;
  logic               out_ar_valid;
  logic               out_ar_ready;
  logic [IW:0]        out_r_id;
  logic [DW-1:0]      out_r_data;
  logic [1:0]         out_r_resp;
  logic               out_r_last;
  logic               out_r_valid;
  logic               out_r_ready;
  logic               dbg_state;
  logic               dbg_rr_ptr;
  logic [1:0][CW-1:0] dbg_cnt;

  axi_rd_join_arbiter #(
    .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .MaxTxns(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_ar_id_i(in_ar_id), .in_ar_addr_i(in_ar_addr), .in_ar_len_i(in_ar_len),
    .in_ar_valid_i(in_ar_valid), .in_ar_ready_o(in_ar_ready),
    .in_r_id_o(in_r_id), .in_r_data_o(in_r_data), .in_r_resp_o(in_r_resp),
    .in_r_last_o(in_r_last), .in_r_valid_o(in_r_valid), .in_r_ready_i(in_r_ready),
    .out_ar_id_o(out_ar_id), .out_ar_addr_o(out_ar_addr), .out_ar_len_o(out_ar_len),
    .out_ar_valid_o(out_ar_valid), .out_ar_ready_i(out_ar_ready),
    .out_r_id_i(out_r_id), .out_r_data_i(out_r_data), .out_r_resp_i(out_r_resp),
    .out_r_last_i(out_r_last), .out_r_valid_i(out_r_valid), .out_r_ready_o(out_r_ready),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_rr_ptr), .dbg_cnt_o(dbg_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [ARW-1:0] exp_ar_q[$];
  logic [RW-1:0]  exp_r_q[$];

  // scoreboard: pop on every handshake seen downstream (AR) or upstream (R)
  always @(negedge clk) begin
    if (!rst) begin
      if (out_ar_valid && out_ar_ready) begin
        logic [ARW-1:0] exp_ar;
        n_vec++;
        if (exp_ar_q.size() == 0) begin
          n_err++;
          $display("FAIL ar_unexpected: got %h, queue empty", {out_ar_id, out_ar_addr, out_ar_len});
        end else begin
          exp_ar = exp_ar_q.pop_front();
          if ({out_ar_id, out_ar_addr, out_ar_len} !== exp_ar) begin
            n_err++;
            $display("FAIL ar_payload: got %h expected %h", {out_ar_id, out_ar_addr, out_ar_len}, exp_ar);
          end
        end
      end
      if (out_r_valid && out_r_ready) begin
        logic [RW-1:0] exp_r;
        n_vec++;
        if (exp_r_q.size() == 0) begin
          n_err++;
          $display("FAIL r_unexpected: got %h, queue empty", {in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last});
        end else begin
          exp_r = exp_r_q.pop_front();
          if ({in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last} !== exp_r) begin
            n_err++;
            $display("FAIL r_beat: got %h expected %h",
                     {in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last}, exp_r);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_ar_valid  = 2'b00;
    out_ar_ready = 1'b0;
    out_r_valid  = 1'b0;
    out_r_last   = 1'b0;
    in_r_ready   = 2'b11;
  endtask

  task automatic drive_ar(input int idx, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
    in_ar_id[idx]    = id;
    in_ar_addr[idx]  = addr;
    in_ar_len[idx]   = len;
    in_ar_valid[idx] = 1'b1;
  endtask

  task automatic push_ar(input int idx);
    exp_ar_q.push_back({idx[0], in_ar_id[idx], in_ar_addr[idx], in_ar_len[idx]});
  endtask

  task automatic send_r(input logic [IW:0] id5, input logic last);
    out_r_id    = id5;
    out_r_data  = {$urandom, $urandom};
    out_r_resp  = 2'($urandom_range(0, 3));
    out_r_last  = last;
    out_r_valid = 1'b1;
    exp_r_q.push_back({(id5[IW] ? 2'b10 : 2'b01), id5[IW-1:0], out_r_data, out_r_resp, last});
  endtask

  task automatic drain_r(input logic idx, input logic [IW-1:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      send_r({idx, id}, 1'b1);
    end
    step();
    out_r_valid = 1'b0;
    out_r_last  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    in_ar_id = '0; in_ar_addr = '0; in_ar_len = '0;
    out_r_id = 5'h10; out_r_data = '0; out_r_resp = '0;
    rst = 1'b1;
    in_ar_valid = 2'b11; out_ar_ready = 1'b1; out_r_valid = 1'b1;
    step(); step();
    @(negedge clk);
    n_vec++;
    if ({out_ar_valid, in_ar_ready, in_r_valid, out_r_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 000000", {out_ar_valid, in_ar_ready, in_r_valid, out_r_ready});
    end
    step();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({dbg_state, dbg_rr_ptr, dbg_cnt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected 000000", {dbg_state, dbg_rr_ptr, dbg_cnt});
    end
  endtask

  task automatic test_single_ar();
    step();
    drive_ar(0, 4'h3, 64'h1000, 8'd0);
    out_ar_ready = 1'b1;
    push_ar(0);
    @(negedge clk);
    n_vec++;
    if (!(out_ar_valid === 1'b1 && out_ar_id === 5'h03 && in_ar_ready === 2'b01)) begin
      n_err++;
      $display("FAIL single_ar: got valid=%b id=%h rdy=%b expected 1 03 01", out_ar_valid, out_ar_id, in_ar_ready);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (dbg_cnt[0] !== 2'd1) begin
      n_err++;
      $display("FAIL single_cnt0: got %0d expected 1", dbg_cnt[0]);
    end
    drain_r(1'b0, 4'h3, 1);
    @(negedge clk);
    n_vec++;
    if (dbg_cnt[0] !== 2'd0) begin
      n_err++;
      $display("FAIL single_drain: got %0d expected 0", dbg_cnt[0]);
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    drive_ar(0, 4'h1, 64'h2000, 8'd1);
    drive_ar(1, 4'h2, 64'h3000, 8'd2);
    out_ar_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      push_ar(k % 2);
      @(negedge clk);
      n_vec++;
      if (out_ar_id[IW] !== 1'(k % 2) || in_ar_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL rr_grant%0d: got grant=%b rdy=%b expected %0d", k, out_ar_id[IW], in_ar_ready, k % 2);
      end
    end
    step();
    @(negedge clk);
    n_vec++;
    if (out_ar_valid !== 1'b0 || dbg_cnt !== {2'd2, 2'd2}) begin
      n_err++;
      $display("FAIL rr_full: got valid=%b cnt=%h expected 0 and 22", out_ar_valid, dbg_cnt);
    end
    clear_inputs();
    drain_r(1'b0, 4'h1, 2);
    drain_r(1'b1, 4'h2, 2);
    @(negedge clk);
    n_vec++;
    if (dbg_cnt !== 4'h0) begin
      n_err++;
      $display("FAIL rr_drain: got %h expected 0", dbg_cnt);
    end
  endtask

  task automatic test_lock();
    step();
    drive_ar(1, 4'h9, 64'h4000, 8'd3);
    out_ar_ready = 1'b0;
    push_ar(1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        drive_ar(0, 4'hA, 64'h5000, 8'd5);
        push_ar(0);
      end
      @(negedge clk);
      n_vec++;
      if (out_ar_id !== 5'h19 || out_ar_addr !== 64'h4000 || in_ar_ready !== 2'b00 || out_ar_valid !== 1'b1) begin
        n_err++;
        $display("FAIL lock_hold%0d: got id=%h addr=%h rdy=%b expected 19 4000 00", c, out_ar_id, out_ar_addr, in_ar_ready);
      end
      step();
    end
    out_ar_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ar_ready !== 2'b10 || out_ar_id !== 5'h19) begin
      n_err++;
      $display("FAIL lock_release: got rdy=%b id=%h expected 10 19", in_ar_ready, out_ar_id);
    end
    step();
    @(negedge clk);
    n_vec++;
    if (in_ar_ready !== 2'b01 || out_ar_id !== 5'h0A) begin
      n_err++;
      $display("FAIL lock_next: got rdy=%b id=%h expected 01 0a", in_ar_ready, out_ar_id);
    end
    step();
    clear_inputs();
    drain_r(1'b1, 4'h9, 1);
    drain_r(1'b0, 4'hA, 1);
  endtask

  task automatic test_throttle();
    step();
    drive_ar(0, 4'h4, 64'h6000, 8'd0);
    out_ar_ready = 1'b1;
    push_ar(0);
    step();
    in_ar_addr[0] = 64'h6040;
    push_ar(0);
    step();
    @(negedge clk);
    n_vec++;
    if (out_ar_valid !== 1'b0 || in_ar_ready !== 2'b00) begin
      n_err++;
      $display("FAIL throttle_hold: got valid=%b rdy=%b expected 0 00", out_ar_valid, in_ar_ready);
    end
    step();
    drive_ar(1, 4'h6, 64'h7000, 8'd1);
    push_ar(1);
    @(negedge clk);
    n_vec++;
    if (in_ar_ready !== 2'b10 || out_ar_id !== 5'h16) begin
      n_err++;
      $display("FAIL throttle_other: got rdy=%b id=%h expected 10 16", in_ar_ready, out_ar_id);
    end
    step();
    in_ar_valid[1] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_ar_valid !== 1'b0 || dbg_cnt !== {2'd1, 2'd2}) begin
      n_err++;
      $display("FAIL throttle_cnt: got valid=%b cnt=%h expected 0 and 12", out_ar_valid, dbg_cnt);
    end
    clear_inputs();
    drain_r(1'b0, 4'h4, 2);
    drain_r(1'b1, 4'h6, 1);
  endtask

  task automatic test_r_burst();
    step();
    drive_ar(1, 4'h5, 64'h8000, 8'd3);
    out_ar_ready = 1'b1;
    push_ar(1);
    step();
    clear_inputs();
    for (int b = 0; b < 4; b++) begin
      step();
      in_r_ready = 2'b11;
      send_r(5'h15, b == 3);
      @(negedge clk);
      n_vec++;
      if (in_r_valid !== 2'b10 || in_r_id !== 4'h5 || dbg_cnt[1] !== 2'd1) begin
        n_err++;
        $display("FAIL burst_beat%0d: got rv=%b id=%h cnt1=%0d expected 10 5 1", b, in_r_valid, in_r_id, dbg_cnt[1]);
      end
      if (b == 1) begin
        step();
        in_r_ready = 2'b01;
        @(negedge clk);
        n_vec++;
        if (out_r_ready !== 1'b0 || in_r_valid !== 2'b10) begin
          n_err++;
          $display("FAIL burst_stall: got ready=%b rv=%b expected 0 10", out_r_ready, in_r_valid);
        end
      end
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (dbg_cnt[1] !== 2'd0) begin
      n_err++;
      $display("FAIL burst_last: got cnt1=%0d expected 0", dbg_cnt[1]);
    end
  endtask

  task automatic test_same_cycle();
    step();
    drive_ar(0, 4'h7, 64'hA000, 8'd0);
    out_ar_ready = 1'b1;
    push_ar(0);
    step();
    in_ar_addr[0] = 64'hA100;
    push_ar(0);
    send_r(5'h07, 1'b1);
    @(negedge clk);
    n_vec++;
    if (in_ar_ready !== 2'b01 || in_r_valid !== 2'b01 || dbg_cnt[0] !== 2'd1) begin
      n_err++;
      $display("FAIL same_pre: got rdy=%b rv=%b cnt0=%0d expected 01 01 1", in_ar_ready, in_r_valid, dbg_cnt[0]);
    end
    step();
    clear_inputs();
    @(negedge clk);
    n_vec++;
    if (dbg_cnt[0] !== 2'd1) begin
      n_err++;
      $display("FAIL same_cycle_cnt: got %0d expected 1", dbg_cnt[0]);
    end
    drain_r(1'b0, 4'h7, 1);
  endtask

  task automatic test_reset_mid_lock();
    step();
    drive_ar(0, 4'h2, 64'hB000, 8'd0);
    out_ar_ready = 1'b1;
    push_ar(0);
    step();
    clear_inputs();
    drive_ar(1, 4'hC, 64'h9000, 8'd7);
    step();
    @(negedge clk);
    n_vec++;
    if (dbg_state !== 1'b1 || out_ar_valid !== 1'b1 || dbg_cnt[0] !== 2'd1) begin
      n_err++;
      $display("FAIL midlock_pre: got st=%b valid=%b cnt0=%0d expected 1 1 1", dbg_state, out_ar_valid, dbg_cnt[0]);
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_ar_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midlock_valid: got %b expected 0", out_ar_valid);
    end
    step();
    rst = 1'b0;
    clear_inputs();
    exp_ar_q.delete();
    exp_r_q.delete();
    @(negedge clk);
    n_vec++;
    if (dbg_state !== 1'b0 || dbg_cnt !== 4'h0 || out_ar_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midlock_post: got st=%b cnt=%h valid=%b expected 0 0 0", dbg_state, dbg_cnt, out_ar_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ar();
    test_round_robin();
    test_lock();
    test_throttle();
    test_r_burst();
    test_same_cycle();
    n_vec++;
    if (exp_ar_q.size() != 0 || exp_r_q.size() != 0) begin
      n_err++;
      $display("FAIL queues_drained: got ar=%0d r=%0d pending expected 0 0", exp_ar_q.size(), exp_r_q.size());
    end
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
